// File: rtl/config_mux.sv
// Configurable N-input routing multiplexer with its own serial configuration chain.
// The selector and the output mode come from a shift register loaded MSB-first via config_in.
module config_mux #(
  parameter int N_INPUTS  = 10,
  parameter int SEL_WIDTH = 4
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [N_INPUTS-1:0] data_in,
  output logic                data_out,
  input  logic                config_in,
  output logic                config_out,
  input  logic                config_enable
);

  localparam int CFG_WIDTH = SEL_WIDTH + 1;
  localparam int LEAVES    = 1 << SEL_WIDTH;

  if (N_INPUTS < 2 || LEAVES < N_INPUTS) begin : g_bad_params
    $error("config_mux: need N_INPUTS >= 2 and 2**SEL_WIDTH >= N_INPUTS");
  end

  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic                 q_q, q_d;
  logic                 mode;
  logic [SEL_WIDTH-1:0] sel;
  logic [LEAVES-1:0]    leaves;
  logic [2*LEAVES-1:1]  node;
  logic                 mux;

  assign mode = cfg_q[SEL_WIDTH];
  assign sel  = cfg_q[SEL_WIDTH-1:0];

  // Heap-ordered halving tree: node j has children 2j and 2j+1, leaf k sits at LEAVES+k.
  // Levels are built bottom-up; sel[u] steers the level u steps above the leaves.
  always_comb begin
    leaves                 = '0;
    leaves[N_INPUTS-1:0]   = data_in;
    node                   = '0;
    node[2*LEAVES-1:LEAVES] = leaves;
    for (int unsigned u = 0; u < SEL_WIDTH; u++) begin
      for (int unsigned j = (1 << (SEL_WIDTH - 1 - u)); j < (2 << (SEL_WIDTH - 1 - u)); j++) begin
        node[j] = sel[u] ? node[2*j+1] : node[2*j];
      end
    end
    mux = node[1];
  end

  always_comb begin
    cfg_d = cfg_q;
    q_d   = mux;
    if (config_enable) begin
      cfg_d = {cfg_q[CFG_WIDTH-2:0], config_in};
      q_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cfg_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      q_q   <= q_d;
    end
  end

  // Data path is forced low while the chain shifts so partial configs never reach the fabric.
  always_comb begin
    data_out = 1'b0;
    if (!config_enable) begin
      data_out = mode ? q_q : mux;
    end
  end

  assign config_out = cfg_q[CFG_WIDTH-1];

endmodule

// File: tb/tb_config_mux.sv
// Self-checking bench for config_mux: vector table, directed corner sequences,
// randomized traffic against a bit-level reference, a 3-deep chain and a parameter sweep.
module tb_config_mux;

  logic       clock;
  logic       nreset;

  logic [9:0] din;
  logic       cen, cin, dout, cout;

  logic [9:0] ch_din;
  logic       ch_cen, ch_cin, c01, c12, ch_cout;
  logic [2:0] ch_dout;

  logic [19:0] sw_din;
  logic        sw_cen, sw_cin;
  logic [2:0]  sw_dout, sw_cout;

  int checks = 0;
  int errors = 0;

  int   cfg_m;
  logic q_m;

  config_mux #(.N_INPUTS(10), .SEL_WIDTH(4)) u_dut (
    .clock(clock), .nreset(nreset), .data_in(din), .data_out(dout),
    .config_in(cin), .config_out(cout), .config_enable(cen)
  );

  config_mux #(.N_INPUTS(10), .SEL_WIDTH(4)) u_c0 (
    .clock(clock), .nreset(nreset), .data_in(ch_din), .data_out(ch_dout[0]),
    .config_in(ch_cin), .config_out(c01), .config_enable(ch_cen)
  );
  config_mux #(.N_INPUTS(10), .SEL_WIDTH(4)) u_c1 (
    .clock(clock), .nreset(nreset), .data_in(ch_din), .data_out(ch_dout[1]),
    .config_in(c01), .config_out(c12), .config_enable(ch_cen)
  );
  config_mux #(.N_INPUTS(10), .SEL_WIDTH(4)) u_c2 (
    .clock(clock), .nreset(nreset), .data_in(ch_din), .data_out(ch_dout[2]),
    .config_in(c12), .config_out(ch_cout), .config_enable(ch_cen)
  );

  config_mux #(.N_INPUTS(2), .SEL_WIDTH(1)) u_sw0 (
    .clock(clock), .nreset(nreset), .data_in(sw_din[1:0]), .data_out(sw_dout[0]),
    .config_in(sw_cin), .config_out(sw_cout[0]), .config_enable(sw_cen)
  );
  config_mux #(.N_INPUTS(16), .SEL_WIDTH(4)) u_sw1 (
    .clock(clock), .nreset(nreset), .data_in(sw_din[15:0]), .data_out(sw_dout[1]),
    .config_in(sw_cin), .config_out(sw_cout[1]), .config_enable(sw_cen)
  );
  config_mux #(.N_INPUTS(20), .SEL_WIDTH(5)) u_sw2 (
    .clock(clock), .nreset(nreset), .data_in(sw_din), .data_out(sw_dout[2]),
    .config_in(sw_cin), .config_out(sw_cout[2]), .config_enable(sw_cen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic mux_ref(int n, int sel, logic [31:0] d);
    if (sel < n) return d[sel];
    return 1'b0;
  endfunction

  function automatic logic exp_dut();
    if (cen) return 1'b0;
    if (((cfg_m >> 4) & 1) == 1) return q_m;
    return mux_ref(10, cfg_m & 15, 32'(din));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  // One clock for u_dut with the reference updated from the pre-edge inputs.
  task automatic tick();
    logic nxt;
    nxt = cen ? 1'b0 : mux_ref(10, cfg_m & 15, 32'(din));
    if (cen) cfg_m = ((cfg_m << 1) | int'(cin)) & 31;
    @(posedge clock);
    q_m = nxt;
    #1;
  endtask

  task automatic load_cfg(input logic [4:0] v);
    cen = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      cin = v[i];
      tick();
      check("safe_load", 32'(dout), 32'd0);
    end
    cen = 1'b0;
    cin = 1'b0;
  endtask

  typedef struct {
    string      nm;
    logic       mode;
    logic [3:0] sel;
    logic [9:0] d;
    logic       exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic        s[30];
    int          n_k[3];
    int          sw_k[3];
    logic        qk[3];
    logic        nxt[3];

    tbl[0] = '{"sel7_hit",   1'b0, 4'd7,  10'b0010000000, 1'b1};
    tbl[1] = '{"sel7_miss",  1'b0, 4'd7,  10'b1101111111, 1'b0};
    tbl[2] = '{"sel0",       1'b0, 4'd0,  10'b0000000001, 1'b1};
    tbl[3] = '{"sel9_top",   1'b0, 4'd9,  10'b1000000000, 1'b1};
    tbl[4] = '{"sel10_oor",  1'b0, 4'd10, 10'b1111111111, 1'b0};
    tbl[5] = '{"sel12_oor",  1'b0, 4'd12, 10'b1111111111, 1'b0};
    tbl[6] = '{"sel15_oor",  1'b0, 4'd15, 10'b1111111111, 1'b0};
    tbl[7] = '{"sel3",       1'b0, 4'd3,  10'b0000001000, 1'b1};
    tbl[8] = '{"sel5_miss",  1'b0, 4'd5,  10'b1111011111, 1'b0};
    n_k  = '{2, 16, 20};
    sw_k = '{1, 4, 5};

    nreset = 1'b0;
    din = 10'b0000000001; cen = 1'b0; cin = 1'b0;
    ch_din = '0; ch_cen = 1'b0; ch_cin = 1'b0;
    sw_din = '0; sw_cen = 1'b0; sw_cin = 1'b0;
    cfg_m = 0; q_m = 1'b0;
    #1;
    check("reset_follow_din0", 32'(dout), 32'd1);
    check("reset_cout", 32'(cout), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    nreset = 1'b1;

    // Asynchronous reset with non-zero cfg and q.
    din = '1;
    load_cfg(5'b10000);
    check("pre_reset_cout", 32'(cout), 32'd1);
    din = 10'b0000000001;
    tick();
    check("pre_reset_reg", 32'(dout), 32'd1);
    #1;
    nreset = 1'b0;
    cfg_m = 0; q_m = 1'b0;
    #1;
    check("reset_cfg", 32'(u_dut.cfg_q), 32'd0);
    check("reset_q", 32'(u_dut.q_q), 32'd0);
    check("reset_cout_async", 32'(cout), 32'd0);
    check("reset_comb_din0", 32'(dout), 32'd1);
    nreset = 1'b1;

    // Vector table, all in combinational mode.
    foreach (tbl[i]) begin
      din = '1;
      load_cfg({tbl[i].mode, tbl[i].sel});
      din = tbl[i].d;
      #1;
      check(tbl[i].nm, 32'(dout), 32'(tbl[i].exp));
    end

    // Combinational: follows data_in without any clock.
    din = '1;
    load_cfg(5'b00111);
    din = 10'b0010000000;
    #1 check("comb_same_cycle", 32'(dout), 32'd1);
    din[7] = 1'b0;
    #1 check("comb_flip_low", 32'(dout), 32'd0);
    din[7] = 1'b1;
    #1 check("comb_flip_high", 32'(dout), 32'd1);

    // Registered mode, sel 3.
    din = '1;
    load_cfg(5'b10011);
    din = 10'b0000001000;
    #1 check("reg_first_cycle_zero", 32'(dout), 32'd0);
    tick();
    check("reg_latency", 32'(dout), 32'd1);
    din = '0;
    #1 check("reg_hold", 32'(dout), 32'd1);
    tick();
    check("reg_low", 32'(dout), 32'd0);
    din[3] = 1'b1;
    #1 check("pulse_not_yet", 32'(dout), 32'd0);
    tick();
    din = '0;
    #1 check("pulse_one_later", 32'(dout), 32'd1);
    tick();
    check("pulse_gone", 32'(dout), 32'd0);
    din[3] = 1'b1;
    tick();
    cen = 1'b1;
    #1 check("enable_forces_zero", 32'(dout), 32'd0);
    cen = 1'b0;
    #1 check("enable_release", 32'(dout), 32'd1);
    din = '0;

    // Reset in the middle of a shift discards the partial configuration.
    cen = 1'b1; cin = 1'b1;
    tick(); tick(); tick();
    nreset = 1'b0;
    cfg_m = 0; q_m = 1'b0;
    #1 check("midshift_reset_cfg", 32'(u_dut.cfg_q), 32'd0);
    nreset = 1'b1;
    cin = 1'b0;
    tick(); tick();
    check("midshift_restart_cfg", 32'(u_dut.cfg_q), 32'(cfg_m));
    check("midshift_restart_zero", 32'(u_dut.cfg_q), 32'd0);
    cen = 1'b0;

    // Randomized traffic against the reference.
    for (int r = 0; r < 40; r++) begin
      din = '1;
      load_cfg(5'($urandom_range(0, 31)));
      for (int c = 0; c < 12; c++) begin
        din = 10'($urandom);
        if ($urandom_range(0, 3) == 0) din = 10'(1) << $urandom_range(0, 9);
        cen = ($urandom_range(0, 7) == 0);
        cin = 1'($urandom);
        #1;
        check("rand_out", 32'(dout), 32'(exp_dut()));
        check("rand_cout", 32'(cout), 32'((cfg_m >> 4) & 1));
        tick();
      end
      cen = 1'b0;
    end

    // Three-deep chain: 15 bits in, first bit reappears 15 clocks later.
    for (int i = 0; i < 30; i++) s[i] = (i < 15) ? 1'($urandom) : 1'b0;
    ch_din = '1;
    ch_cen = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      ch_cin = s[n-1];
      @(posedge clock);
      #1;
      check("chain_safe", 32'(ch_dout), 32'd0);
      check("chain_cout", 32'(ch_cout), (n >= 15) ? 32'(s[n-15]) : 32'd0);
      if (n == 15) begin
        int e2, e1, e0;
        e2 = 0; e1 = 0; e0 = 0;
        for (int i = 0; i < 5; i++) begin
          e2 = e2 * 2 + int'(s[i]);
          e1 = e1 * 2 + int'(s[5+i]);
          e0 = e0 * 2 + int'(s[10+i]);
        end
        check("chain_cfg2", 32'(u_c2.cfg_q), 32'(e2));
        check("chain_cfg1", 32'(u_c1.cfg_q), 32'(e1));
        check("chain_cfg0", 32'(u_c0.cfg_q), 32'(e0));
      end
    end
    ch_cen = 1'b0;

    // Parameter sweep: a 6-bit stream loads the low CFG_WIDTH bits of v into each instance.
    for (int v = 0; v < 64; v++) begin
      logic [5:0] vb;
      vb = 6'(v);
      sw_din = '1;
      sw_cen = 1'b1;
      for (int i = 5; i >= 0; i--) begin
        sw_cin = vb[i];
        @(posedge clock);
        #1;
        check("sweep_safe", 32'(sw_dout), 32'd0);
      end
      sw_cen = 1'b0;
      sw_cin = 1'b0;
      qk = '{1'b0, 1'b0, 1'b0};
      for (int p = 0; p <= 20; p++) begin
        sw_din = (p < 20) ? (20'(1) << p) : 20'd0;
        #1;
        for (int k = 0; k < 3; k++) begin
          int cfg_k, sel_k, mode_k;
          logic mx;
          cfg_k  = v % (1 << (sw_k[k] + 1));
          mode_k = cfg_k >> sw_k[k];
          sel_k  = cfg_k & ((1 << sw_k[k]) - 1);
          mx     = mux_ref(n_k[k], sel_k, 32'(sw_din));
          check("sweep_out", 32'(sw_dout[k]), (mode_k == 1) ? 32'(qk[k]) : 32'(mx));
          nxt[k] = mx;
        end
        @(posedge clock);
        qk = nxt;
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_mux.md
# config_mux

Parametrised N-input configurable multiplexer for the routing fabric, generalising the fixed 10-input selector into a block with its own serial configuration chain and a selectable registered output. The selector and the output mode are held in an internal configuration shift register loaded through the daisy-chained bitstream path (`config_in` → `config_out`). The block sits inside connection and switch boxes, driven by routing tracks, and feeds LE inputs or outgoing tracks.

## Interface
- `N_INPUTS`, default 10: number of data inputs; legal range ≥ 2.
- `SEL_WIDTH`, default 4: selector width; must satisfy 2^SEL_WIDTH ≥ N_INPUTS.
- `CFG_WIDTH`, derived, SEL_WIDTH+1: configuration register length. Not overridable.

- `clock`  in  1: single clock; all state updates on its rising edge.
- `nreset`  in  1: reset, asynchronous, active-low.
- `data_in`  in  N_INPUTS: routing inputs.
- `data_out`  out  1: selected input, combinational or registered per mode.
- `config_in`  in  1: serial configuration bit from the previous block in the chain.
- `config_out`  out  1: serial configuration bit to the next block; equals `cfg[CFG_WIDTH-1]`.
- `config_enable`  in  1: when high, the configuration chain shifts and the data path is held safe.

## Operation
- Configuration register `cfg[CFG_WIDTH-1:0]`:
  - `cfg[SEL_WIDTH]` is `mode`: 0 = combinational output, 1 = registered output.
  - `cfg[SEL_WIDTH-1:0]` is `sel`.
- Shift rule: on a clock edge with `config_enable`=1, `cfg <= {cfg[CFG_WIDTH-2:0], config_in}`. With `config_enable`=0, `cfg` holds.
- Load order: the first bit shifted in ends at the MSB. The stream is `mode`, then `sel` MSB first, so CFG_WIDTH shifts load one block.
- The chain is pure shift. Blocks in series form one long register with no gaps or extra latency.
- Selection: `mux = data_in[sel]` when `sel` < N_INPUTS, otherwise `mux = 0`. This is a binary halving tree of SEL_WIDTH levels, with out-of-range leaves tied to 0.
- Output FF `q`:
  - When `config_enable`=0, `q <= mux` on each edge.
  - When `config_enable`=1, `q <= 0`.
- `data_out`:
  - When `config_enable`=1, `data_out` = 0 regardless of mode. This is the safe-routing requirement: no glitch propagation during reconfiguration.
  - Otherwise `data_out` = `mux` if `mode`=0, else `q`.
- Reset (`nreset`=0, asynchronous): `cfg` = 0 (sel 0, combinational mode) and `q` = 0. `config_out` = 0 immediately. `data_out` follows `data_in[0]` combinationally while reset is held with `config_enable`=0.
- Reset mid-shift: the partial configuration is discarded. The chain restarts from all zeros after `nreset` deasserts.
- Mode change: when `mode` goes 0→1 at the end of loading, `data_out` is 0 for the first cycle after `config_enable` falls, because `q` was cleared. The input value is visible from the following edge.

## Timing
- Combinational mode: zero latency from `data_in`/`sel` to `data_out`.
- Registered mode: one clock of latency from `data_in` to `data_out`.
- `config_out` changes only on clock edges (or asynchronously on reset). It is one clock per position behind `config_in`, so bit k emerges CFG_WIDTH clocks after entry.
- `config_enable` is sampled only at clock edges for `cfg` and `q`. Its forcing of `data_out` to 0 is combinational.
- A new `cfg` takes effect on `data_out` in the same cycle it is registered.

## Test plan
- Reset: assert `nreset`=0 mid-cycle with `cfg` nonzero → `cfg`=0, `config_out`=0, `q`=0 at once. With `data_in`=10'b0000000001, `data_out`=1.
- Combinational select (N_INPUTS=10): shift in `0,0,1,1,1` (mode 0, sel 7), drop `config_enable`, `data_in`=10'b0010000000 → `data_out`=1 in the same cycle. Flip bit 7 → `data_out` follows with no clock.
- Out-of-range: load sel=12 (mode 0), drive `data_in` all ones → `data_out`=0. Also cover sel=15.
- Registered mode: load `1,0,0,1,1` (mode 1, sel 3). Pulse `data_in[3]` high for one cycle → `data_out` is 1 exactly one cycle later. First cycle after `config_enable` falls → `data_out`=0.
- Chain: cascade 3 instances, shift 15 bits. Verify each instance's `cfg` and that `config_out` of the last instance reproduces the first bit 15 clocks after entry. During the shift, every `data_out`=0.
- Parameter sweep: N_INPUTS=2/SEL_WIDTH=1, N_INPUTS=16/SEL_WIDTH=4, N_INPUTS=20/SEL_WIDTH=5 → exhaustive `sel` × one-hot `data_in` check against the reference model in both modes.
